// File: rtl/sram_arbiter.sv
// sram_arbiter: arbitrates an instruction-fetch port and an execute-stage port onto one
// external asynchronous SRAM. EXE has strict priority; one transaction in flight at a time.
// Optional one-entry fetch buffer compiled in with `define SRAM_IF_BUF_EN.
`timescale 1ns/1ps
module sram_arbiter #(
    parameter int unsigned ADDR_W   = 18,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned WAIT_CYC = 2    // strobe length in cycles, 1..15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              exe_req,
    input  logic              exe_we,
    input  logic [ADDR_W-1:0] exe_addr,
    input  logic [DATA_W-1:0] exe_wdata,
    output logic              exe_ack,
    output logic [DATA_W-1:0] exe_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_data,
    output logic              sram_en_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              busy,
    output logic [3:0]        state_out
);

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StSetup    = 4'd1,
        StRdStrobe = 4'd2,
        StWrStrobe = 4'd3,
        StDone     = 4'd4
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              sel_exe_q, sel_exe_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] exe_rdata_q, exe_rdata_d;
    logic              grant_if;
    logic              data_oe;

`ifdef SRAM_IF_BUF_EN
    logic              buf_valid_q, buf_valid_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [DATA_W-1:0] buf_data_q, buf_data_d;
    logic              buf_ack_q, buf_ack_d;
`endif

    // Next-state: arbitration in IDLE, strobe timing, read-data capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_exe_d   = sel_exe_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        exe_rdata_d = exe_rdata_q;
        grant_if    = 1'b0;
`ifdef SRAM_IF_BUF_EN
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        buf_ack_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (exe_req) begin
                    sel_exe_d = 1'b1;
                    we_d      = exe_we;
                    addr_d    = exe_addr;
                    wdata_d   = exe_wdata;
                    state_d   = StSetup;
`ifdef SRAM_IF_BUF_EN
                    if (exe_we && (exe_addr == buf_addr_q)) begin
                        buf_valid_d = 1'b0;
                    end
`endif
                end else if (if_req) begin
`ifdef SRAM_IF_BUF_EN
                    // A buffered ack is visible this cycle; the held req is not a new one.
                    if (!buf_ack_q) begin
                        if (buf_valid_q && (if_addr == buf_addr_q)) begin
                            buf_ack_d  = 1'b1;
                            if_rdata_d = buf_data_q;
                        end else begin
                            grant_if = 1'b1;
                        end
                    end
`else
                    grant_if = 1'b1;
`endif
                end
                if (grant_if) begin
                    sel_exe_d = 1'b0;
                    we_d      = 1'b0;
                    addr_d    = if_addr;
                    wdata_d   = exe_wdata;
                    state_d   = StSetup;
                end
            end
            StSetup: begin
                cnt_d   = 4'(WAIT_CYC - 1);
                state_d = we_q ? StWrStrobe : StRdStrobe;
            end
            StRdStrobe: begin
                if (cnt_q == 4'd0) begin
                    state_d = StDone;
                    if (sel_exe_q) begin
                        exe_rdata_d = sram_data;
                    end else begin
                        if_rdata_d = sram_data;
`ifdef SRAM_IF_BUF_EN
                        buf_valid_d = 1'b1;
                        buf_addr_d  = addr_q;
                        buf_data_d  = sram_data;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StWrStrobe: begin
                if (cnt_q == 4'd0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and latch registers; reset aborts any transaction at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            sel_exe_q   <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            exe_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_exe_q   <= sel_exe_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            exe_rdata_q <= exe_rdata_d;
        end
    end

`ifdef SRAM_IF_BUF_EN
    // Fetch buffer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            buf_ack_q   <= 1'b0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            buf_ack_q   <= buf_ack_d;
        end
    end
`endif

    // Bus strobes decoded from state so reset releases them without a clock.
    always_comb begin
        sram_en_n = (state_q == StIdle);
        sram_oe_n = (state_q != StRdStrobe);
        sram_we_n = (state_q != StWrStrobe);
        data_oe   = (state_q == StWrStrobe) || ((state_q == StDone) && we_q);
        busy      = (state_q != StIdle);
        state_out = state_q;
        exe_ack   = (state_q == StDone) && sel_exe_q;
`ifdef SRAM_IF_BUF_EN
        if_ack    = ((state_q == StDone) && !sel_exe_q) || buf_ack_q;
`else
        if_ack    = (state_q == StDone) && !sel_exe_q;
`endif
    end

    assign sram_addr = addr_q;
    assign sram_data = data_oe ? wdata_q : {DATA_W{1'bz}};
    assign if_rdata  = if_rdata_q;
    assign exe_rdata = exe_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter (WAIT_CYC=2). Stimulus pushes expected acks;
// a monitor pops and checks port, cycle and read data on every ack.
`timescale 1ns/1ps
module tb_sram_arbiter;
    localparam int AW = 18;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, exe_req, exe_we;
    logic [AW-1:0] if_addr, exe_addr;
    logic [DW-1:0] exe_wdata;
    logic          if_ack, exe_ack, sram_en_n, sram_oe_n, sram_we_n, busy;
    logic [DW-1:0] if_rdata, exe_rdata;
    logic [AW-1:0] sram_addr;
    logic [3:0]    state_out;
    wire  [DW-1:0] sram_data;

    sram_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .exe_req   (exe_req),
        .exe_we    (exe_we),
        .exe_addr  (exe_addr),
        .exe_wdata (exe_wdata),
        .exe_ack   (exe_ack),
        .exe_rdata (exe_rdata),
        .sram_addr (sram_addr),
        .sram_data (sram_data),
        .sram_en_n (sram_en_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n),
        .busy      (busy),
        .state_out (state_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: unwritten words read as 0xA000 | addr[7:0].
    logic [DW-1:0] mem [256];
    bit            mem_vld [256];
    wire  [7:0]    mad = sram_addr[7:0];
    logic [DW-1:0] rd_word;
    assign rd_word   = mem_vld[mad] ? mem[mad] : (16'hA000 | {8'h00, mad});
    assign sram_data = (!sram_en_n && !sram_oe_n && sram_we_n) ? rd_word : {DW{1'bz}};
    always @(negedge clk) begin
        if (!sram_en_n && !sram_we_n) begin
            mem[mad]     <= sram_data;
            mem_vld[mad] <= 1'b1;
        end
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit            is_exe;
        int            cyc;
        bit            chk;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sbq[$];

    task automatic expect_ack(input bit is_exe, input int c, input bit chk,
                              input logic [DW-1:0] d);
        exp_t e;
        e.is_exe = is_exe;
        e.cyc    = c;
        e.chk    = chk;
        e.data   = d;
        sbq.push_back(e);
    endtask

    // Monitor: every ack must match the head of the scoreboard.
    always @(negedge clk) begin
        if (if_ack || exe_ack) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_ack: if_ack=%0b exe_ack=%0b at cycle %0d, none required",
                         if_ack, exe_ack, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("ack_port", {30'b0, exe_ack, if_ack}, e.is_exe ? 32'd2 : 32'd1);
                check("ack_cycle", cyc, e.cyc);
                if (e.chk) begin
                    check("ack_rdata", e.is_exe ? exe_rdata : if_rdata, e.data);
                end
            end
        end
    end

    logic          s_en [16], s_oe [16], s_we [16], s_busy [16];
    logic [DW-1:0] s_bus [16];
    logic [3:0]    s_st [16];

    // Run n cycles from posedge+1; record outputs at each negedge, drop req after its ack.
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            bit ia, ea;
            @(negedge clk);
            s_en[i]   = sram_en_n;
            s_oe[i]   = sram_oe_n;
            s_we[i]   = sram_we_n;
            s_busy[i] = busy;
            s_bus[i]  = sram_data;
            s_st[i]   = state_out;
            ia        = if_ack;
            ea        = exe_ack;
            @(posedge clk);
            #1;
            if (ia) if_req = 1'b0;
            if (ea) exe_req = 1'b0;
        end
    endtask

    int c0;

    initial begin
        rst = 1'b1;
        if_req = 1'b0; exe_req = 1'b0; exe_we = 1'b0;
        if_addr = '0; exe_addr = '0; exe_wdata = '0;
        #1 rst = 1'b0;
        #2;
        // Reset values, before any clock edge.
        check("rst_state", state_out, 0);
        check("rst_en_n", sram_en_n, 1);
        check("rst_oe_n", sram_oe_n, 1);
        check("rst_we_n", sram_we_n, 1);
        check("rst_busy", busy, 0);
        check("rst_acks", {if_ack, exe_ack}, 0);
        check("rst_rdata", {if_rdata, exe_rdata}, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // EXE write 0x00123 / 0xBEEF.
        exe_req = 1'b1; exe_we = 1'b1; exe_addr = 18'h00123; exe_wdata = 16'hBEEF;
        c0 = cyc;
        expect_ack(1'b1, c0 + 4, 1'b0, '0);
        run_cycles(6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("wr_we_n_c%0d", i), s_we[i], (i == 2 || i == 3) ? 0 : 1);
            check($sformatf("wr_en_n_c%0d", i), s_en[i], (i >= 1 && i <= 4) ? 0 : 1);
            if (i >= 2 && i <= 4) check($sformatf("wr_bus_c%0d", i), s_bus[i], 16'hBEEF);
            else check($sformatf("wr_bus_released_c%0d", i), s_bus[i] !== 16'hBEEF, 1);
        end
        check("wr_state_c1", s_st[1], 1);

        // EXE read 0x00123 returns 0xBEEF; bus not driven by the arbiter.
        exe_req = 1'b1; exe_we = 1'b0;
        c0 = cyc;
        expect_ack(1'b1, c0 + 4, 1'b1, 16'hBEEF);
        run_cycles(6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("rd_oe_n_c%0d", i), s_oe[i], (i == 2 || i == 3) ? 0 : 1);
            check($sformatf("rd_we_n_c%0d", i), s_we[i], 1);
            if (i != 2 && i != 3) check($sformatf("rd_bus_hiz_c%0d", i), s_bus[i] !== 16'hBEEF, 1);
        end

        // Simultaneous IF 0x00010 and EXE read 0x00020: EXE first.
        if_req = 1'b1; if_addr = 18'h00010;
        exe_req = 1'b1; exe_we = 1'b0; exe_addr = 18'h00020;
        c0 = cyc;
        expect_ack(1'b1, c0 + 4, 1'b1, 16'hA020);
        expect_ack(1'b0, c0 + 9, 1'b1, 16'hA010);
        run_cycles(11);
        check("arb_idle_c5", s_st[5], 0);
        check("arb_if_setup_c6", s_st[6], 1);
        check("arb_en_n_c5", s_en[5], 1);
        check("arb_busy_c7", s_busy[7], 1);
        check("arb_exe_rdata_hold", exe_rdata, 16'hA020);
        check("arb_if_rdata_hold", if_rdata, 16'hA010);

        // Reset in the second WR_STROBE cycle aborts the write.
        exe_req = 1'b1; exe_we = 1'b1; exe_addr = 18'h00040; exe_wdata = 16'h1357;
        run_cycles(3);
        check("abort_pre_state", state_out, 3);
        check("abort_pre_we_n", sram_we_n, 0);
        rst = 1'b0;
        #1;
        check("abort_we_n", sram_we_n, 1);
        check("abort_en_n", sram_en_n, 1);
        check("abort_busy", busy, 0);
        check("abort_state", state_out, 0);
        check("abort_bus_hiz", sram_data !== 16'h1357, 1);
        check("abort_rdata_clr", {if_rdata, exe_rdata}, 0);
        exe_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        run_cycles(3);
        for (int i = 0; i < 3; i++) check($sformatf("abort_idle_c%0d", i), s_st[i], 0);

        // IF 0x00010 twice, then EXE write 0x00010/0x1234, then IF 0x00010 again.
        if_req = 1'b1; if_addr = 18'h00010;
        c0 = cyc;
        expect_ack(1'b0, c0 + 4, 1'b1, 16'hA010);
        run_cycles(6);
        check("if1_en_n_c1", s_en[1], 0);
        if_req = 1'b1;
        c0 = cyc;
`ifdef SRAM_IF_BUF_EN
        expect_ack(1'b0, c0 + 1, 1'b1, 16'hA010);
        run_cycles(3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("buf_en_n_c%0d", i), s_en[i], 1);
            check($sformatf("buf_busy_c%0d", i), s_busy[i], 0);
        end
`else
        expect_ack(1'b0, c0 + 4, 1'b1, 16'hA010);
        run_cycles(6);
        check("if2_en_n_c1", s_en[1], 0);
`endif
        exe_req = 1'b1; exe_we = 1'b1; exe_addr = 18'h00010; exe_wdata = 16'h1234;
        c0 = cyc;
        expect_ack(1'b1, c0 + 4, 1'b0, '0);
        run_cycles(6);
        if_req = 1'b1;
        c0 = cyc;
        expect_ack(1'b0, c0 + 4, 1'b1, 16'h1234);
        run_cycles(6);
        check("if3_en_n_c1", s_en[1], 0);
        check("if3_oe_n_c2", s_oe[2], 0);

        check("sb_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst.
REQ-002 Parameter ADDR_W, default 18: external SRAM address width.
REQ-003 Parameter DATA_W, default 16: SRAM and port data width.
REQ-004 Parameter WAIT_CYC, default 2: strobe length in clk cycles; legal range 1..15.
REQ-005 Port clk, input, 1: clock; all state changes on the rising edge.
REQ-006 Port rst, input, 1: asynchronous reset, active low.
REQ-007 Port if_req, input, 1: instruction-fetch read request, level, held until if_ack.
REQ-008 Port if_addr, input, ADDR_W: fetch address, stable while if_req is high.
REQ-009 Port if_ack, output, 1: one-cycle pulse; if_rdata is valid in that cycle and holds its value afterwards.
REQ-010 Port if_rdata, output, DATA_W: fetched word.
REQ-011 Ports exe_req (input, 1), exe_we (input, 1), exe_addr (input, ADDR_W) and exe_wdata (input, DATA_W): execute-stage access; exe_we=1 means write; all are stable while exe_req is high.
REQ-012 Ports exe_ack (output, 1) and exe_rdata (output, DATA_W): completion pulse and read data, with the same rules as the IF port.
REQ-013 Ports sram_addr (output, ADDR_W), sram_data (inout, DATA_W), sram_en_n (output, 1), sram_oe_n (output, 1) and sram_we_n (output, 1): the external asynchronous SRAM.
REQ-014 Port busy, output, 1: high in every non-IDLE state.
REQ-015 Port state_out, output, 4: current FSM state code for debug.

Function
REQ-016 FSM states: IDLE, SETUP, RD_STROBE, WR_STROBE, DONE.
- IDLE SHALL sample the requests.
- exe_req SHALL have strict priority over if_req.
- On grant: latch port select, address, write flag and write data into internal registers; go to SETUP.
REQ-017 SETUP (1 cycle):
- sram_addr SHALL be driven from the latched address.
- sram_oe_n=1 and sram_we_n=1.
- Next state: RD_STROBE for a read, WR_STROBE for a write.
REQ-018 RD_STROBE (WAIT_CYC cycles):
- sram_oe_n=0.
- sram_data SHALL be captured into the granted port's rdata at the end of the last strobe cycle.
REQ-019 WR_STROBE (WAIT_CYC cycles):
- sram_we_n=0.
- sram_data SHALL be driven with the latched write data.
REQ-020 DONE (1 cycle):
- sram_oe_n=1 and sram_we_n=1.
- For a write, data SHALL still be driven (hold time).
- The granted port's ack SHALL pulse.
- Next state: IDLE.
REQ-021 Latency: a request seen in IDLE cycle k SHALL be acked in cycle k+WAIT_CYC+2; only one transaction is in flight at any time.
REQ-022 sram_data SHALL be driven only in WR_STROBE and in DONE after a write; it SHALL be high-Z in all other states.
REQ-023 sram_en_n SHALL be 0 in all non-IDLE states and 1 in IDLE.
REQ-024 A req still high in the IDLE cycle after its ack SHALL be treated as a new request; requesters SHALL drop req on the edge at which they see ack.
REQ-025 The strobe counter SHALL be 4 bits, load WAIT_CYC-1, and count down to 0 with no wrap.
REQ-026 If IF and EXE requests arrive in the same cycle, IF SHALL wait and be granted in the IDLE cycle after EXE's DONE, unless a new exe_req is present in that cycle.

Reset
REQ-027 While rst=0, independent of clk:
- state=IDLE;
- sram_en_n, sram_oe_n and sram_we_n all 1;
- sram_data high-Z;
- acks 0, rdata 0, busy 0;
- internal latches and the fetch buffer cleared.
REQ-028 Reset asserted mid-transaction SHALL abort it with no ack; strobes SHALL deassert immediately.

Configuration
REQ-029 With macro SRAM_IF_BUF_EN defined, a one-entry fetch buffer (address, data, valid) SHALL be compiled in:
- Every completed IF read SHALL fill the buffer.
- An if_req in IDLE whose if_addr matches a valid entry SHALL be acked in the next cycle from the buffer, with no SRAM access and sram_en_n held at 1.
- An EXE write to the buffered address SHALL clear valid on grant.
- EXE priority still applies.
REQ-030 Without SRAM_IF_BUF_EN, every IF request SHALL perform a full SRAM read, and no buffer logic SHALL exist.

Verification
All scenarios use WAIT_CYC=2, with request cycle = 0.
REQ-031 EXE write 0x00123/0xBEEF -> sram_we_n=0 in cycles 2-3; data driven in cycles 2-4; exe_ack in cycle 4; if_ack stays 0.
REQ-032 EXE read 0x00123 after the write, with the SRAM model returning 0xBEEF -> sram_oe_n=0 in cycles 2-3; exe_ack with exe_rdata=0xBEEF in cycle 4; sram_data high-Z throughout.
REQ-033 if_req at 0x00010 and exe_req read at 0x00020 in the same cycle -> exe_ack in cycle 4; IF SETUP in cycle 6; if_ack in cycle 9.
REQ-034 rst driven low in the second WR_STROBE cycle -> sram_we_n and sram_en_n = 1 and sram_data high-Z within the same cycle; no ack; FSM in IDLE after release.
REQ-035 With SRAM_IF_BUF_EN, IF read 0x00010 twice -> second if_ack one cycle after the request, with sram_en_n staying 1. Then EXE write 0x00010/0x1234 followed by IF read 0x00010 -> full bus read, if_rdata=0x1234.
